// File: rtl/pooling_max_unit.sv
// -----------------------------------------------------------------------------
// pooling_max_unit
//
// Max-pooling reducer for a serial float32 stream. Every KERNEL_SIZE*KERNEL_SIZE
// accepted samples form one window. The window maximum is presented on a
// registered valid/ready output.
//
// Optional build macro:
//   POOL_RELU_EN - when defined, a finished non-NaN result whose sign bit is set
//                  (including -0) is loaded into out_data as 32'h0000_0000.
//                  This fuses a ReLU into the output register.
//
// Ports:
//   clk        in   1           clock
//   rst_n      in   1           asynchronous active-low reset
//   clear      in   1           synchronous flush of the partial window and pending result
//   in_valid   in   1           in_data is valid this cycle
//   in_ready   out  1           block accepts in_data this cycle
//   in_data    in   DATA_WIDTH  float32 sample
//   out_valid  out  1           out_data holds a finished window maximum
//   out_ready  in   1           consumer takes out_data this cycle
//   out_data   out  DATA_WIDTH  window maximum (float32)
//   win_cnt    out  6           samples accumulated in the current window
//   nan_seen   out  1           sticky: a NaN was accepted since reset/clear
// -----------------------------------------------------------------------------
module pooling_max_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            win_cnt,
  output logic                  nan_seen
);

  localparam int                  WIN_LEN  = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [5:0]          LAST_CNT = 6'(WIN_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] CANON_NAN = DATA_WIDTH'(32'h7FC0_0000);

  // NaN: exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // True when b is strictly greater than a in IEEE ordering (NaN excluded).
  // +0 and -0 are treated as equal, so a tie keeps the earlier operand a.
  function automatic logic b_wins(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    logic [30:0] mag_a;
    logic [30:0] mag_b;
    mag_a = a[30:0];
    mag_b = b[30:0];
    if ((mag_a == 31'd0) && (mag_b == 31'd0)) begin
      b_wins = 1'b0;
    end else if (a[31] != b[31]) begin
      b_wins = !b[31];
    end else if (!a[31]) begin
      b_wins = (mag_b > mag_a);
    end else begin
      b_wins = (mag_b < mag_a);
    end
  endfunction

  logic [5:0]            win_cnt_q,   win_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q,       acc_d;
  logic                  win_nan_q,   win_nan_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  nan_seen_q,  nan_seen_d;

  logic                  in_ready_s;
  logic                  acc_s;
  logic                  is_last_s;
  logic                  in_nan_s;
  logic                  win_nan_any_s;
  logic [DATA_WIDTH-1:0] cand_max_s;
  logic [DATA_WIDTH-1:0] result_s;

  // Only the closing sample of a window stalls, and only while a result is still pending.
  assign is_last_s  = (win_cnt_q == LAST_CNT);
  assign in_ready_s = !(is_last_s && out_valid_q && !out_ready);
  assign acc_s      = in_valid && in_ready_s;

  // Datapath: running maximum candidate and the finished-window result.
  always_comb begin
    in_nan_s      = is_nan(in_data);
    win_nan_any_s = win_nan_q || in_nan_s;
    cand_max_s    = b_wins(acc_q, in_data) ? in_data : acc_q;
    result_s      = win_nan_any_s ? CANON_NAN : cand_max_s;
`ifdef POOL_RELU_EN
    if (!win_nan_any_s && result_s[DATA_WIDTH-1]) begin
      result_s = '0;
    end else begin
      result_s = result_s;
    end
`else
    result_s = result_s;
`endif
  end

  // Next-state logic for window counter, accumulator, flags and output register.
  always_comb begin
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    win_nan_d   = win_nan_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    nan_seen_d  = nan_seen_q;

    if (clear) begin
      // A flush discards the partial window, the pending result and any sample in flight.
      win_cnt_d   = 6'd0;
      acc_d       = '0;
      win_nan_d   = 1'b0;
      out_valid_d = 1'b0;
      nan_seen_d  = 1'b0;
    end else begin
      if (acc_s && in_nan_s) begin
        nan_seen_d = 1'b1;
      end else begin
        nan_seen_d = nan_seen_q;
      end

      if (acc_s) begin
        if (win_cnt_q == 6'd0) begin
          // First sample opens a new window and restarts its NaN tracking.
          acc_d     = in_data;
          win_nan_d = in_nan_s;
          win_cnt_d = 6'd1;
        end else if (!is_last_s) begin
          acc_d     = cand_max_s;
          win_nan_d = win_nan_any_s;
          win_cnt_d = win_cnt_q + 6'd1;
        end else begin
          win_nan_d = 1'b0;
          win_cnt_d = 6'd0;
        end
      end else begin
        win_cnt_d = win_cnt_q;
      end

      // A closing sample reloads the output even while the old result drains.
      if (acc_s && is_last_s) begin
        out_data_d  = result_s;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= 6'd0;
      acc_q       <= '0;
      win_nan_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      nan_seen_q  <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      win_nan_q   <= win_nan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      nan_seen_q  <= nan_seen_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_cnt   = win_cnt_q;
  assign nan_seen  = nan_seen_q;

endmodule

// File: tb/tb_pooling_max_unit.sv
// -----------------------------------------------------------------------------
// tb_pooling_max_unit
//
// Directed bench for pooling_max_unit with KERNEL_SIZE=2 (four samples per window).
// A table of hand-computed windows is streamed first. Hand-written sequences then
// cover backpressure, clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pooling_max_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  win_cnt;
  logic        nan_seen;

  int tests_run    = 0;
  int tests_failed = 0;

  pooling_max_unit #(.DATA_WIDTH(32), .KERNEL_SIZE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .win_cnt   (win_cnt),
    .nan_seen  (nan_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] d;
    logic [31:0]      exp_raw;
    logic [31:0]      exp_relu;
    logic             exp_nan;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3,
                              input logic [31:0] raw, input logic [31:0] relu,
                              input logic nan);
    vec_t v;
    v.d[0] = s0; v.d[1] = s1; v.d[2] = s2; v.d[3] = s3;
    v.exp_raw = raw; v.exp_relu = relu; v.exp_nan = nan;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one sample and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [31:0] x);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stuck at 0 for sample %08h", x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;

    vecs[0] = mk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000, 32'h40000000, 32'h40000000, 1'b0);
    vecs[1] = mk(32'hBF800000, 32'hC0400000, 32'hBF000000, 32'hC0000000, 32'hBF000000, 32'h00000000, 1'b0);
    vecs[2] = mk(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    vecs[3] = mk(32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h00000001, 32'h7F800000, 32'h7F800000, 1'b0);
    vecs[4] = mk(32'h00000001, 32'h00000003, 32'h00000002, 32'h80000005, 32'h00000003, 32'h00000003, 1'b0);
    vecs[5] = mk(32'hFF800000, 32'h80000001, 32'hFF7FFFFF, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    vecs[6] = mk(32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    vecs[7] = mk(32'h80000000, 32'h7FC00001, 32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b1);
    vecs[8] = mk(32'hFF800000, 32'hFFFFFFFF, 32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 1'b1);

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check1 ("rst_in_ready",  in_ready,  1'b1);
    check1 ("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_data",  out_data,  32'h0);
    check6 ("rst_win_cnt",   win_cnt,   6'd0);
    check1 ("rst_nan_seen",  nan_seen,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven windows with a free-running consumer.
    for (int i = 0; i < 9; i++) begin
`ifdef POOL_RELU_EN
      exp = vecs[i].exp_relu;
`else
      exp = vecs[i].exp_raw;
`endif
      for (int k = 0; k < 3; k++) send(vecs[i].d[k]);
      check1 ($sformatf("vec%0d_pre_valid", i), out_valid, 1'b0);
      check6 ($sformatf("vec%0d_pre_cnt", i),   win_cnt,   6'd3);
      send(vecs[i].d[3]);
      check1 ($sformatf("vec%0d_valid", i),    out_valid, 1'b1);
      check32($sformatf("vec%0d_data", i),     out_data,  exp);
      check6 ($sformatf("vec%0d_cnt", i),      win_cnt,   6'd0);
      check1 ($sformatf("vec%0d_nan_seen", i), nan_seen,  vecs[i].exp_nan);
    end
    @(posedge clk); #1;
    check1("drain_valid", out_valid, 1'b0);

    // Clear drops the sticky NaN flag.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check1("clear_nan_seen", nan_seen, 1'b0);

    // Backpressure: eight samples with the consumer stalled.
    out_ready = 1'b0;
    send(32'h3F800000); send(32'h40000000); send(32'h3F000000); send(32'hBF800000);
    check1 ("bp_first_valid", out_valid, 1'b1);
    check32("bp_first_data",  out_data,  32'h40000000);
    send(32'h40400000); send(32'h3F800000); send(32'h40800000);
    check6 ("bp_cnt3",        win_cnt,   6'd3);
    check32("bp_hold_data",   out_data,  32'h40000000);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    #1;
    check1("bp_stall", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check1 ("bp_stall_hold",  in_ready,  1'b0);
    check32("bp_stable_data", out_data,  32'h40000000);
    check1 ("bp_stable_valid", out_valid, 1'b1);
    check6 ("bp_stable_cnt",  win_cnt,   6'd3);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check1("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1 ("bp_second_valid", out_valid, 1'b1);
    check32("bp_second_data",  out_data,  32'h40800000);
    check6 ("bp_second_cnt",   win_cnt,   6'd0);
    @(posedge clk); #1;
    check1("bp_drained", out_valid, 1'b0);

    // Clear mid-window discards earlier samples and the concurrent one.
    send(32'h40800000); send(32'h7FC00001);
    check6("clr_cnt2",   win_cnt,  6'd2);
    check1("clr_nan_pre", nan_seen, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check6("clr_cnt0",  win_cnt,   6'd0);
    check1("clr_nan",   nan_seen,  1'b0);
    check1("clr_valid", out_valid, 1'b0);
    send(32'h3F800000); send(32'h3F800000); send(32'h3F800000);
    check1("clr_no_early", out_valid, 1'b0);
    send(32'h3F800000);
    check1 ("clr_res_valid", out_valid, 1'b1);
    check32("clr_res_data",  out_data,  32'h3F800000);
    check1 ("clr_res_nan",   nan_seen,  1'b0);
    @(posedge clk); #1;
    check1("clr_single", out_valid, 1'b0);

    // Asynchronous reset with a pending result and a partial window.
    out_ready = 1'b0;
    send(32'h3F800000); send(32'h40000000); send(32'h3F000000); send(32'hBF800000);
    send(32'h40400000); send(32'h7FC00001);
    check1("ar_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1 ("ar_valid",    out_valid, 1'b0);
    check6 ("ar_cnt",      win_cnt,   6'd0);
    check1 ("ar_in_ready", in_ready,  1'b1);
    check32("ar_data",     out_data,  32'h0);
    check1 ("ar_nan",      nan_seen,  1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h3F800000); send(32'h40000000); send(32'h3F000000); send(32'hBF800000);
    check1 ("ar_post_valid", out_valid, 1'b1);
    check32("ar_post_data",  out_data,  32'h40000000);
    check1 ("ar_post_nan",   nan_seen,  1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
